// File: rtl/cga_vram_arbiter_if.sv
// ISA-side memory bus seen by the CGA VRAM arbiter.
//
// Handshake: the ISA master starts a cycle by pulling bus_memr_l or bus_memw_l
// low (asynchronously) with bus_a/bus_d stable. The arbiter answers with
// bus_rdy: while bus_rdy is 0 the master must hold the strobe, address and data.
// When bus_rdy returns to 1 the cycle is complete (read data is on bus_out and
// bus_dir is 1 for reads). The master ends the cycle by releasing both strobes.
// A new cycle is only accepted after both strobes have been seen high.
interface cga_vram_arbiter_if;
    logic [19:0] bus_a;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic        bus_aen;
    logic [7:0]  bus_d;
    logic [7:0]  bus_out;
    logic        bus_dir;
    logic        bus_rdy;

    modport master (
        output bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d,
        input  bus_out, bus_dir, bus_rdy
    );

    modport slave (
        input  bus_a, bus_memr_l, bus_memw_l, bus_aen, bus_d,
        output bus_out, bus_dir, bus_rdy
    );
endinterface

// File: rtl/cga_vram_arbiter.sv
// CGA video RAM arbiter: the display fetch owns the single-port VRAM except
// for a fixed two-clock CPU slot in the sequencer period. CPU ISA cycles to
// the framebuffer are held off with bus_rdy until their slot comes round.
module cga_vram_arbiter #(
    parameter bit          USE_BUS_WAIT  = 1'b1,
    parameter logic [19:0] FB_BASE       = 20'hB8000,
    parameter logic [4:0]  CPU_WIN_START = 5'd17,
    parameter logic [4:0]  SEQ_LAST      = 5'd31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               clk_seq,
    input  logic                     tandy_32k,
    input  logic [18:0]              disp_addr,
    input  logic                     disp_we_l,
    cga_vram_arbiter_if.slave        isa,
    output logic [18:0]              ram_a,
    output logic                     ram_we_l,
    output logic [7:0]               ram_wd,
    input  logic [7:0]               ram_d,
    output logic [2:0]               fsm_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACC  = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // The WAIT->ACC transition is taken one slot early so that the RAM
    // access itself (state ACC) lands on clk_seq == CPU_WIN_START.
    localparam logic [4:0] GRANT_SEQ = (CPU_WIN_START == 5'd0) ? SEQ_LAST
                                                               : CPU_WIN_START - 5'd1;

    state_t      state;
    logic        memr_m, memr_s;
    logic        memw_m, memw_s;
    logic [14:0] addr_q;
    logic [7:0]  wd_q;
    logic        wr_q;
    logic        sel;
    logic [14:0] cpu_off;

    assign sel     = (isa.bus_a[19:15] == FB_BASE[19:15]) & ~isa.bus_aen;
    // 16K CGA map forces A14 low, so BC000-BFFFF mirrors B8000-BBFFF.
    assign cpu_off = {tandy_32k ? isa.bus_a[14] : 1'b0, isa.bus_a[13:0]};
    assign ram_wd    = wd_q;
    assign fsm_state = state;

    // Two-flop synchronizers for the asynchronous ISA strobes (idle high).
    always_ff @(posedge clk) begin
        if (reset) begin
            memr_m <= 1'b1;
            memr_s <= 1'b1;
            memw_m <= 1'b1;
            memw_s <= 1'b1;
        end else begin
            memr_m <= isa.bus_memr_l;
            memr_s <= memr_m;
            memw_m <= isa.bus_memw_l;
            memw_s <= memw_m;
        end
    end

    // CPU cycle FSM: request latch, window wait, access, capture, completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            isa.bus_rdy <= 1'b1;
            isa.bus_dir <= 1'b0;
            isa.bus_out <= 8'h00;
            addr_q      <= 15'h0000;
            wd_q        <= 8'h00;
            wr_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel && (!memr_s || !memw_s)) begin
                        addr_q <= cpu_off;
                        wd_q   <= isa.bus_d;
                        wr_q   <= ~memw_s;  // write wins when both strobes are low
                        if (USE_BUS_WAIT) begin
                            state       <= WAIT;
                            isa.bus_rdy <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                WAIT: begin
                    if (memr_s && memw_s) begin
                        state       <= IDLE;
                        isa.bus_rdy <= 1'b1;
                    end else if (clk_seq == GRANT_SEQ) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    state <= CAP;
                end
                CAP: begin
                    if (!wr_q) begin
                        isa.bus_out <= ram_d;
                    end
                    isa.bus_rdy <= 1'b1;
                    isa.bus_dir <= ~wr_q & ~memr_s;
                    state       <= DONE;
                end
                DONE: begin
                    // Stay here until both strobes are seen high, so a strobe
                    // held or re-asserted without release never starts a cycle.
                    if (memr_s && memw_s) begin
                        state       <= IDLE;
                        isa.bus_dir <= 1'b0;
                    end else begin
                        isa.bus_dir <= ~wr_q & ~memr_s;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // VRAM mux: display passes through except during the CPU ACC/CAP slot;
    // the write strobe is forced inactive while reset is asserted.
    always_comb begin
        ram_a    = disp_addr;
        ram_we_l = disp_we_l;
        if (reset) begin
            ram_we_l = 1'b1;
        end else if (state == ACC) begin
            ram_a    = {4'h0, addr_q};
            ram_we_l = ~wr_q;
        end else if (state == CAP) begin
            ram_a    = {4'h0, addr_q};
            ram_we_l = 1'b1;
        end
    end

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Bench for cga_vram_arbiter: a window-scheduled instance and an
// immediate-grant instance share the ISA stimulus; each has its own RAM model.
module tb_cga_vram_arbiter;

    typedef struct {
        logic [19:0] a;
        logic        rd;
        logic        wr;
        logic        aen;
        logic        tandy;
        logic [7:0]  d;
        logic [4:0]  start;
        logic        hit;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [4:0]  clk_seq;
    logic        tandy;
    logic [18:0] disp_addr;
    logic        disp_we_l;
    logic [19:0] bus_a;
    logic        memr_l, memw_l, aen;
    logic [7:0]  bus_d;

    logic [18:0] ram_a_w, ram_a_n;
    logic        ram_we_l_w, ram_we_l_n;
    logic [7:0]  ram_wd_w, ram_wd_n;
    logic [7:0]  ram_d_w, ram_d_n;
    logic [2:0]  st_w, st_n;

    int tests = 0;
    int fails = 0;
    logic [27:0] exp_q[$];

    cga_vram_arbiter_if if_w();
    cga_vram_arbiter_if if_n();

    assign if_w.bus_a = bus_a;   assign if_n.bus_a = bus_a;
    assign if_w.bus_memr_l = memr_l; assign if_n.bus_memr_l = memr_l;
    assign if_w.bus_memw_l = memw_l; assign if_n.bus_memw_l = memw_l;
    assign if_w.bus_aen = aen;   assign if_n.bus_aen = aen;
    assign if_w.bus_d = bus_d;   assign if_n.bus_d = bus_d;

    cga_vram_arbiter #(.USE_BUS_WAIT(1'b1)) u_w (
        .clk(clk), .reset(reset), .clk_seq(clk_seq), .tandy_32k(tandy),
        .disp_addr(disp_addr), .disp_we_l(disp_we_l), .isa(if_w.slave),
        .ram_a(ram_a_w), .ram_we_l(ram_we_l_w), .ram_wd(ram_wd_w),
        .ram_d(ram_d_w), .fsm_state(st_w)
    );

    cga_vram_arbiter #(.USE_BUS_WAIT(1'b0)) u_n (
        .clk(clk), .reset(reset), .clk_seq(clk_seq), .tandy_32k(tandy),
        .disp_addr(disp_addr), .disp_we_l(disp_we_l), .isa(if_n.slave),
        .ram_a(ram_a_n), .ram_we_l(ram_we_l_n), .ram_wd(ram_wd_n),
        .ram_d(ram_d_n), .fsm_state(st_n)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ram_model(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h78;
    endfunction

    function automatic logic [18:0] off_of(input logic [19:0] a, input logic t);
        return {4'h0, t ? a[14] : 1'b0, a[13:0]};
    endfunction

    function automatic vec_t mk(input logic [19:0] a, input logic rd, input logic wr,
                                input logic ae, input logic t, input logic [7:0] d,
                                input logic [4:0] s, input logic hit);
        vec_t v;
        v.a = a; v.rd = rd; v.wr = wr; v.aen = ae; v.tandy = t;
        v.d = d; v.start = s; v.hit = hit;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: RAM models return data for the address presented last cycle,
    // the sequencer counter advances, outputs are then sampled 1ns after the edge.
    task automatic tick();
        logic [18:0] pa_w, pa_n;
        pa_w = ram_a_w;
        pa_n = ram_a_n;
        @(posedge clk);
        #1;
        ram_d_w = ram_model(pa_w);
        ram_d_n = ram_model(pa_n);
        clk_seq = (clk_seq == 5'd31) ? 5'd0 : clk_seq + 5'd1;
    endtask

    task automatic wait_seq(input logic [4:0] s);
        for (int i = 0; i < 40 && clk_seq != s; i++) tick();
    endtask

    task automatic release_check(input string name);
        memr_l = 1'b1;
        memw_l = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check({name, "_release"}, 32'({if_w.bus_dir, if_w.bus_rdy}), 32'h1);
        check({name, "_disp_a"}, 32'(ram_a_w), 32'(disp_addr));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int rdy_low = 0;
        int cpu_cyc = 0;
        int we_cnt = 0;
        int acc_seq = -1;
        int rdy_seq = -1;
        bit done = 0;
        bit prev_rdy = 1;
        logic dir_done = 0;
        logic [18:0] acc_addr = '0;
        logic [18:0] off;
        logic [27:0] obs = '0;
        logic [27:0] e;
        string nm;
        nm = $sformatf("v%0d", idx);
        off = off_of(v.a, v.tandy);
        wait_seq(v.start);
        bus_a = v.a; aen = v.aen; tandy = v.tandy; bus_d = v.d;
        memr_l = ~v.rd; memw_l = ~v.wr;
        if (v.hit) exp_q.push_back({v.wr, off, v.wr ? v.d : ram_model(off)});
        for (int c = 0; c < 70 && !done; c++) begin
            tick();
            if (!if_w.bus_rdy) rdy_low++;
            if (ram_a_w[18:15] == 4'h0) begin
                if (acc_seq < 0) begin
                    acc_seq = int'(clk_seq);
                    acc_addr = ram_a_w;
                end
                cpu_cyc++;
            end
            if (!ram_we_l_w) begin
                we_cnt++;
                obs = {1'b1, ram_a_w, ram_wd_w};
            end
            if (v.hit && !prev_rdy && if_w.bus_rdy) begin
                done = 1;
                rdy_seq = int'(clk_seq);
                dir_done = if_w.bus_dir;
                if (!v.wr) obs = {1'b0, acc_addr, if_w.bus_out};
            end
            prev_rdy = if_w.bus_rdy;
        end
        if (v.hit) begin
            if (!done) begin
                tests++; fails++;
                $display("FAIL %s_timeout: bus_rdy never returned within 70 clks", nm);
            end
            check({nm, "_acc_seq"}, 32'(acc_seq), 32'd17);
            check({nm, "_cpu_cycles"}, 32'(cpu_cyc), 32'd2);
            check({nm, "_we_pulses"}, 32'(we_cnt), v.wr ? 32'd1 : 32'd0);
            check({nm, "_rdy_seq"}, 32'(rdy_seq), 32'd19);
            check({nm, "_dir"}, 32'(dir_done), v.wr ? 32'd0 : 32'd1);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s_sb: no expected entry, got 0x%0h", nm, obs);
            end else begin
                e = exp_q.pop_front();
                check({nm, "_sb"}, 32'(obs), 32'(e));
            end
        end else begin
            check({nm, "_no_wait"}, 32'(rdy_low), 32'd0);
            check({nm, "_no_cpu"}, 32'(cpu_cyc), 32'd0);
            check({nm, "_no_we"}, 32'(we_cnt), 32'd0);
        end
        release_check(nm);
    endtask

    vec_t vecs[8];

    initial begin
        int rdy_low, cpu_cyc, we_cnt, dir_low, acc_seq, bound;
        logic [18:0] acc_addr;
        logic [27:0] e;
        bit seen;

        vecs[0] = mk(20'hB8123, 1, 0, 0, 0, 8'h00, 5'd2,  1);
        vecs[1] = mk(20'hBC010, 0, 1, 0, 0, 8'hA5, 5'd3,  1);
        vecs[2] = mk(20'hBC7FF, 1, 0, 0, 1, 8'h00, 5'd20, 1);
        vecs[3] = mk(20'hBFFFF, 0, 1, 0, 1, 8'h3C, 5'd14, 1);
        vecs[4] = mk(20'hB0000, 1, 0, 0, 0, 8'h00, 5'd4,  0);
        vecs[5] = mk(20'hB8000, 1, 0, 1, 0, 8'h00, 5'd6,  0);
        vecs[6] = mk(20'hBA000, 1, 1, 0, 0, 8'h77, 5'd8,  1);
        vecs[7] = mk({5'b10111, 15'($urandom_range(0, 32767))}, 0, 1, 0, 1,
                     8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)), 1);

        // Reset
        reset = 1'b1; clk_seq = 5'd0; tandy = 1'b0;
        disp_addr = 19'h78000 | 19'($urandom_range(0, 4095));
        disp_we_l = 1'b0;
        bus_a = 20'h00000; memr_l = 1'b1; memw_l = 1'b1; aen = 1'b0; bus_d = 8'h00;
        ram_d_w = 8'h00; ram_d_n = 8'h00;
        tick(); tick();
        check("rst_state", 32'(st_w), 32'd0);
        check("rst_rdy", 32'(if_w.bus_rdy), 32'd1);
        check("rst_dir", 32'(if_w.bus_dir), 32'd0);
        check("rst_out", 32'(if_w.bus_out), 32'd0);
        check("rst_we", 32'(ram_we_l_w), 32'd1);
        check("rst_wd", 32'(ram_wd_w), 32'd0);
        check("rst_rdy_n", 32'(if_n.bus_rdy), 32'd1);
        reset = 1'b0;
        tick();
        check("pass_we_low", 32'(ram_we_l_w), 32'd0);
        check("pass_addr", 32'(ram_a_w), 32'(disp_addr));
        disp_we_l = 1'b1;
        #1;
        check("pass_we_high", 32'(ram_we_l_w), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Strobe held through DONE: no second access, rdy and dir stay up.
        wait_seq(5'd2);
        bus_a = 20'hB8200; aen = 1'b0; tandy = 1'b0; memr_l = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (if_w.bus_rdy && if_w.bus_dir) seen = 1;
        end
        check("hold_done", 32'(seen), 32'd1);
        check("hold_out", 32'(if_w.bus_out), 32'(ram_model(19'h00200)));
        cpu_cyc = 0; rdy_low = 0; dir_low = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ram_a_w[18:15] == 4'h0) cpu_cyc++;
            if (!if_w.bus_rdy) rdy_low++;
            if (!if_w.bus_dir) dir_low++;
        end
        check("hold_no_cpu", 32'(cpu_cyc), 32'd0);
        check("hold_rdy", 32'(rdy_low), 32'd0);
        check("hold_dir", 32'(dir_low), 32'd0);
        release_check("hold");

        // Write aborted before its window: no RAM write, rdy restored.
        wait_seq(5'd3);
        bus_a = 20'hBA000; bus_d = 8'h11; memw_l = 1'b0;
        rdy_low = 0; we_cnt = 0; cpu_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (clk_seq == 5'd10) memw_l = 1'b1;
            tick();
            if (!if_w.bus_rdy) rdy_low++;
            if (!ram_we_l_w) we_cnt++;
            if (ram_a_w[18:15] == 4'h0) cpu_cyc++;
        end
        check("abort_seen", 32'(rdy_low > 0), 32'd1);
        check("abort_no_we", 32'(we_cnt), 32'd0);
        check("abort_no_cpu", 32'(cpu_cyc), 32'd0);
        check("abort_rdy", 32'(if_w.bus_rdy), 32'd1);
        check("abort_state", 32'(st_w), 32'd0);

        // Reset while waiting for the window.
        wait_seq(5'd2);
        bus_a = 20'hB8040; memr_l = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("rstw_pending", 32'(if_w.bus_rdy), 32'd0);
        reset = 1'b1; memr_l = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw_state", 32'(st_w), 32'd0);
        check("rstw_rdy", 32'(if_w.bus_rdy), 32'd1);
        check("rstw_addr", 32'(ram_a_w), 32'(disp_addr));

        // Reset during the write slot: the strobe is cut on the reset clock.
        for (int i = 0; i < 4; i++) tick();
        wait_seq(5'd2);
        bus_a = 20'hB8055; bus_d = 8'hC9; memw_l = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (!ram_we_l_w) seen = 1;
        end
        check("rsta_reached", 32'(seen), 32'd1);
        reset = 1'b1; memw_l = 1'b1;
        #1;
        check("rsta_we_cut", 32'(ram_we_l_w), 32'd1);
        tick();
        reset = 1'b0;
        check("rsta_state", 32'(st_w), 32'd0);
        check("rsta_rdy", 32'(if_w.bus_rdy), 32'd1);
        check("rsta_out", 32'(if_w.bus_out), 32'd0);
        tick();
        check("rsta_we_idle", 32'(ram_we_l_w), 32'd1);

        // Immediate-grant instance: 32K map read, no wait states.
        for (int i = 0; i < 4; i++) tick();
        wait_seq(5'd5);
        bus_a = 20'hBC7FF; tandy = 1'b1; memr_l = 1'b0;
        exp_q.push_back({1'b0, 19'h047FF, ram_model(19'h047FF)});
        rdy_low = 0; cpu_cyc = 0; acc_seq = -1; acc_addr = '0; seen = 0;
        bound = 12;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!if_n.bus_rdy) rdy_low++;
            if (ram_a_n[18:15] == 4'h0) begin
                if (acc_seq < 0) begin
                    acc_seq = int'(clk_seq);
                    acc_addr = ram_a_n;
                end
                cpu_cyc++;
            end
            if (clk_seq == 5'd10) begin
                seen = 1;
                check("nw_dir", 32'(if_n.bus_dir), 32'd1);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL nw_sb: no expected entry, got 0x%0h", if_n.bus_out);
                end else begin
                    e = exp_q.pop_front();
                    check("nw_sb", 32'({1'b0, acc_addr, if_n.bus_out}), 32'(e));
                end
            end
        end
        check("nw_sampled", 32'(seen), 32'd1);
        check("nw_no_wait", 32'(rdy_low), 32'd0);
        check("nw_acc_seq", 32'(acc_seq), 32'd8);
        check("nw_cpu_cycles", 32'(cpu_cyc), 32'd2);
        memr_l = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("nw_release", 32'({if_n.bus_dir, if_n.bus_rdy}), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
